// File: rtl/serial_adder_seq.sv
// Bit-serial adder controller: feeds an external single-bit full adder one bit pair
// per cycle, LSB first, and assembles the WIDTH-bit result plus final carry.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  aSh_q;
   logic [WIDTH-1:0]  bSh_q;
   logic [WIDTH-1:0]  sumSh_q;
   logic [WIDTH-1:0]  sumSh_d;
   logic              carry_q;
   logic [CW-1:0]     cnt_q;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;

   // Returned sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
   generate
      if (WIDTH == 1) begin : gSingle
         assign sumSh_d = fa_sum;
      end else begin : gMulti
         assign sumSh_d = {fa_sum, sumSh_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aSh_q   <= '0;
         bSh_q   <= '0;
         sumSh_q <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  aSh_q   <= A;
                  bSh_q   <= B;
                  carry_q <= Cin;
                  cnt_q   <= '0;
                  sumSh_q <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sumSh_q <= sumSh_d;
               carry_q <= fa_cout;
               aSh_q   <= aSh_q >> 1;
               bSh_q   <= bSh_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_q   <= sumSh_d;
                  cout_q  <= fa_cout;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Full-adder feeds are gated by the state flop so the adder sees zeros outside RUN.
   assign fa_a   = (state_q == RUN) & aSh_q[0];
   assign fa_b   = (state_q == RUN) & bSh_q[0];
   assign fa_cin = (state_q == RUN) & carry_q;
   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign Sum    = sum_q;
   assign Cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq with an ideal full adder closing the loop;
// expected results come from a table and from plain A+B+Cin arithmetic.
module tb_serial_adder_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] expSum;
      logic       expCout;
   } vec_t;

   vec_t vecs[6];

   serial_adder_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
      .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
   );

   // Behavioural stand-in for the external full adder built from half adders.
   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Launches one addition and follows it to the done pulse, checking the handshake.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                output logic [7:0] sumOut, output logic coutOut);
      int lat;
      int busyCnt;
      nextCycle();
      A = a; B = b; Cin = cin; start = 1'b1;
      nextCycle();
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      checkOutput("fa_first_bits", {29'd0, fa_a, fa_b, fa_cin}, {29'd0, a[0], b[0], cin});
      lat = 0;
      busyCnt = 0;
      while (!done && lat < 30) begin
         if (busy) busyCnt++;
         nextCycle();
         lat++;
      end
      checkOutput("done_latency", lat, 8);
      checkOutput("busy_cycles", busyCnt, 8);
      checkOutput("busy_in_done", {31'd0, busy}, 0);
      sumOut  = Sum;
      coutOut = Cout;
      nextCycle();
      checkOutput("done_single_pulse", {31'd0, done}, 0);
      checkOutput("fa_idle_zero", {29'd0, fa_a, fa_b, fa_cin}, 0);
   endtask

   initial begin
      logic [7:0] s;
      logic       c;
      logic [8:0] ref9;
      int         doneSeen;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
      vecs[4] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
      vecs[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};

      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (3) nextCycle();
      checkOutput("reset_sum", Sum, 0);
      checkOutput("reset_cout", {31'd0, Cout}, 0);
      checkOutput("reset_busy_done", {30'd0, busy, done}, 0);
      checkOutput("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
      rst_n = 1'b1;
      nextCycle();

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, s, c);
         checkOutput($sformatf("vec%0d_sum", i), s, vecs[i].expSum);
         checkOutput($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].expCout});
      end

      // Start pulses during RUN and DONE must be ignored.
      $display("[TB] ignored-start sequence");
      nextCycle();
      A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (2) nextCycle();
      A = 8'h11; B = 8'h22; start = 1'b1;
      nextCycle();
      start = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 12 && !done; k++) nextCycle();
      checkOutput("ign_done_reached", {31'd0, done}, 1);
      checkOutput("ign_sum", Sum, 8'h10);
      checkOutput("ign_cout", {31'd0, Cout}, 0);
      start = 1'b1;
      nextCycle();
      start = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (done || busy) doneSeen++;
         nextCycle();
      end
      checkOutput("ign_no_second_op", doneSeen, 0);
      applyStimulus(8'h12, 8'h11, 1'b1, s, c);
      checkOutput("after_ign_sum", s, 8'h24);

      // Asynchronous reset in the middle of RUN.
      $display("[TB] mid-run reset sequence");
      applyStimulus(8'h0F, 8'h01, 1'b0, s, c);
      nextCycle();
      A = 8'h55; B = 8'h11; start = 1'b1;
      nextCycle();
      start = 1'b0;
      repeat (3) nextCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'd0, busy}, 0);
      checkOutput("midrst_sum", Sum, 0);
      checkOutput("midrst_cout", {31'd0, Cout}, 0);
      nextCycle();
      rst_n = 1'b1;
      doneSeen = 0;
      for (int k = 0; k < 12; k++) begin
         if (done) doneSeen++;
         nextCycle();
      end
      checkOutput("midrst_no_done", doneSeen, 0);
      applyStimulus(8'h80, 8'h80, 1'b0, s, c);
      checkOutput("post_rst_sum", s, 8'h00);
      checkOutput("post_rst_cout", {31'd0, c}, 1);

      // Result must hold while idle inputs wander.
      applyStimulus(8'h12, 8'h34, 1'b0, s, c);
      checkOutput("hold_first_sum", s, 8'h46);
      for (int k = 0; k < 20; k++) begin
         A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
         nextCycle();
         checkOutput("hold_sum", {23'd0, Cout, Sum}, {23'd0, 1'b0, 8'h46});
      end

      // Random operands against plain arithmetic.
      for (int k = 0; k < 25; k++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         applyStimulus(ra, rb, rc, s, c);
         checkOutput($sformatf("rand%0d", k), {23'd0, c, s}, {23'd0, ref9});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
